sif_mult_arb: RTL and testbench

- Shares one sif_mult instance between N_REQ requesters.
- Round-robin arbitration; at most one operand pair issued per cycle.
- Each issue is tagged with the requester ID. Results return in issue order and are buffered in a result FIFO carrying the ID.
- sif_mult has no backpressure, so issue is credit-limited: every in-flight product is guaranteed a FIFO slot.

---
 rtl/sif_mult_arb.sv | 193 +++++++++++++++++++
 tb/tb_sif_mult_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sif_mult_arb.sv
// Round-robin arbiter sharing one sif_mult between N_REQ requesters, with credit-limited issue
// and an in-order, ID-tagged result FIFO. Define SIF_MULT_ARB_STATS_EN to add issue/stall counters.
module sif_mult_arb #(
  parameter int WIDTH      = 32,
  parameter int N_REQ      = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_vld,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_rdy,
  output logic                   mul_a_vld,
  output logic [WIDTH-1:0]       mul_a_dat,
  output logic                   mul_b_vld,
  output logic [WIDTH-1:0]       mul_b_dat,
  input  logic                   mul_p_vld,
  input  logic [WIDTH-1:0]       mul_p_dat,
  output logic                   res_vld,
  output logic [WIDTH-1:0]       res_dat,
  output logic [ID_W-1:0]        res_id,
  input  logic                   res_rdy
`ifdef SIF_MULT_ARB_STATS_EN
  ,
  output logic [31:0]            stat_issue,
  output logic [31:0]            stat_stall
`endif
);

  localparam int TA_W  = $clog2(TAG_DEPTH);
  localparam int RA_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W = TA_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TAG_FULL  = CNT_W'(TAG_DEPTH);

  logic [WIDTH-1:0] a_slice [N_REQ];
  logic [WIDTH-1:0] b_slice [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic [ID_W-1:0]  rr_ptr_reg;
  logic [ID_W-1:0]  grant_id;
  logic             found;
  logic             issue_ok;
  logic             accept;
  logic [CNT_W-1:0] tag_cnt_reg;
  logic [CNT_W-1:0] res_cnt_reg;
  logic [CNT_W-1:0] credit;

  // Credit counts queued results and products still inside the multiplier alike.
  assign credit   = FIFO_FULL - res_cnt_reg - tag_cnt_reg;
  assign issue_ok = !rst && (credit != '0) && (tag_cnt_reg != TAG_FULL);

  always_comb begin
    int idx;
    found    = 1'b0;
    grant_id = '0;
    req_rdy  = '0;
    idx      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr_reg) + k) % N_REQ;
      if (!found && req_vld[idx]) begin
        found    = 1'b1;
        grant_id = ID_W'(idx);
      end
    end
    if (found && issue_ok) req_rdy[grant_id] = 1'b1;
  end

  assign accept = found && issue_ok;

  logic             mul_vld_reg;
  logic [WIDTH-1:0] mul_a_reg;
  logic [WIDTH-1:0] mul_b_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg  <= '0;
      mul_vld_reg <= 1'b0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
    end else begin
      mul_vld_reg <= accept;
      if (accept) begin
        mul_a_reg  <= a_slice[grant_id];
        mul_b_reg  <= b_slice[grant_id];
        rr_ptr_reg <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  assign mul_a_vld = mul_vld_reg;
  assign mul_b_vld = mul_vld_reg;
  assign mul_a_dat = mul_a_reg;
  assign mul_b_dat = mul_b_reg;

  // Tag FIFO: requester IDs of products in flight, popped as each product returns.
  logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
  logic [TA_W-1:0]  tag_wr_ptr_reg;
  logic [TA_W-1:0]  tag_rd_ptr_reg;
  logic             tag_pop;
  logic             drop;
  logic             drop_err_reg;

  assign tag_pop = mul_p_vld && (tag_cnt_reg != '0);
  assign drop    = mul_p_vld && (tag_cnt_reg == '0);

  logic [WIDTH-1:0] res_dat_mem [FIFO_DEPTH];
  logic [ID_W-1:0]  res_id_mem  [FIFO_DEPTH];
  logic [RA_W-1:0]  res_wr_ptr_reg;
  logic [RA_W-1:0]  res_rd_ptr_reg;
  logic             res_push;
  logic             res_pop;

  assign res_push = tag_pop;
  assign res_pop  = res_vld && res_rdy;

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr_ptr_reg] <= grant_id;
    if (res_push) begin
      res_dat_mem[res_wr_ptr_reg] <= mul_p_dat;
      res_id_mem[res_wr_ptr_reg]  <= tag_mem[tag_rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr_ptr_reg <= '0;
      tag_rd_ptr_reg <= '0;
      tag_cnt_reg    <= '0;
      res_wr_ptr_reg <= '0;
      res_rd_ptr_reg <= '0;
      res_cnt_reg    <= '0;
      drop_err_reg   <= 1'b0;
    end else begin
      if (accept)   tag_wr_ptr_reg <= tag_wr_ptr_reg + TA_W'(1);
      if (tag_pop)  tag_rd_ptr_reg <= tag_rd_ptr_reg + TA_W'(1);
      if (res_push) res_wr_ptr_reg <= res_wr_ptr_reg + RA_W'(1);
      if (res_pop)  res_rd_ptr_reg <= res_rd_ptr_reg + RA_W'(1);
      case ({accept, tag_pop})
        2'b10:   tag_cnt_reg <= tag_cnt_reg + CNT_W'(1);
        2'b01:   tag_cnt_reg <= tag_cnt_reg - CNT_W'(1);
        default: tag_cnt_reg <= tag_cnt_reg;
      endcase
      case ({res_push, res_pop})
        2'b10:   res_cnt_reg <= res_cnt_reg + CNT_W'(1);
        2'b01:   res_cnt_reg <= res_cnt_reg - CNT_W'(1);
        default: res_cnt_reg <= res_cnt_reg;
      endcase
      if (drop) drop_err_reg <= 1'b1;
    end
  end

  assign res_vld = (res_cnt_reg != '0);
  assign res_dat = res_vld ? res_dat_mem[res_rd_ptr_reg] : '0;
  assign res_id  = res_vld ? res_id_mem[res_rd_ptr_reg]  : '0;

  a_res_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(res_push && (res_cnt_reg == FIFO_FULL)));
  a_drop_flagged: assert property (@(posedge clk) disable iff (rst)
    drop |=> drop_err_reg);

`ifdef SIF_MULT_ARB_STATS_EN
  logic [31:0] stat_issue_reg;
  logic [31:0] stat_stall_reg;
  logic        stall;

  assign stall = (|req_vld) && !issue_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issue_reg <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (accept && (stat_issue_reg != '1)) stat_issue_reg <= stat_issue_reg + 32'd1;
      if (stall && (stat_stall_reg != '1))  stat_stall_reg <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_issue = stat_issue_reg;
  assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_sif_mult_arb.sv
// Bench for sif_mult_arb: fixed-latency multiplier model, queue-based reference model,
// a vector table for round-robin order, and hand sequences for backpressure and reset.
module tb_sif_mult_arb;
  localparam int WIDTH      = 32;
  localparam int N_REQ      = 4;
  localparam int ID_W       = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int TAG_DEPTH  = 16;
  localparam int MUL_LAT    = 4;
  localparam int RES_LAT    = MUL_LAT + 2;  // accept cycle to first res_vld cycle

  logic                   clk, rst;
  logic [N_REQ-1:0]       req_vld, req_rdy;
  logic [N_REQ*WIDTH-1:0] req_a, req_b;
  logic                   mul_a_vld, mul_b_vld, mul_p_vld;
  logic [WIDTH-1:0]       mul_a_dat, mul_b_dat, mul_p_dat, mul_prod;
  logic                   res_vld, res_rdy;
  logic [WIDTH-1:0]       res_dat;
  logic [ID_W-1:0]        res_id;
`ifdef SIF_MULT_ARB_STATS_EN
  logic [31:0]            stat_issue, stat_stall;
`endif

  sif_mult_arb #(.WIDTH(WIDTH), .N_REQ(N_REQ), .ID_W(ID_W),
                 .FIFO_DEPTH(FIFO_DEPTH), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .mul_a_vld(mul_a_vld), .mul_a_dat(mul_a_dat),
    .mul_b_vld(mul_b_vld), .mul_b_dat(mul_b_dat), .mul_p_vld(mul_p_vld),
    .mul_p_dat(mul_p_dat), .res_vld(res_vld), .res_dat(res_dat), .res_id(res_id),
    .res_rdy(res_rdy)
`ifdef SIF_MULT_ARB_STATS_EN
    , .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in: fixed latency, no reset, so in-flight products survive a DUT reset.
  logic             mul_clr;
  logic [WIDTH:0]   mpipe [MUL_LAT];
  assign mul_prod  = mul_a_dat * mul_b_dat;
  assign mul_p_vld = mpipe[MUL_LAT-1][WIDTH];
  assign mul_p_dat = mpipe[MUL_LAT-1][WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (mul_clr) begin
      for (int i = 0; i < MUL_LAT; i++) mpipe[i] <= '0;
    end else begin
      mpipe[0] <= {mul_a_vld & mul_b_vld, mul_prod};
      for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end

  typedef struct { logic [ID_W-1:0] id; logic [WIDTH-1:0] dat; int ready; } exp_t;
  typedef struct { logic [N_REQ-1:0] vld; logic [N_REQ-1:0] exp_rdy; } vec_t;

  exp_t             exp_q[$];
  vec_t             tbl[10];
  int               rr_m, outstanding, cyc;
  logic             prev_acc;
  logic [WIDTH-1:0] prev_a, prev_b;
  logic [WIDTH-1:0] a_val [N_REQ];
  logic [WIDTH-1:0] b_val [N_REQ];
  int               n_cmp, n_err, dut_acc, dut_pop;
  logic [N_REQ-1:0] last_req_rdy;
  logic             last_res_vld;
  logic [WIDTH-1:0] last_res_dat, last_pop_dat;
  logic [ID_W-1:0]  last_res_id, last_pop_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = a_val[i];
      req_b[i*WIDTH +: WIDTH] = b_val[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N_REQ; i++) begin
      a_val[i] = $urandom;
      b_val[i] = $urandom;
    end
    drive_ops();
  endtask

  task automatic model_reset();
    exp_q.delete();
    rr_m        = 0;
    outstanding = 0;
    prev_acc    = 1'b0;
  endtask

  task automatic check_reset(input string name);
    chk({name, "_req_rdy"}, 64'(req_rdy), 64'd0);
    chk({name, "_mul_vld"}, 64'({mul_a_vld, mul_b_vld}), 64'd0);
    chk({name, "_mul_dat"}, 64'({mul_a_dat, mul_b_dat}), 64'd0);
    chk({name, "_res"}, 64'({res_vld, res_id, res_dat}), 64'd0);
  endtask

  // One clock: check DUT against the model at negedge, advance the model, return at posedge+1.
  task automatic step();
    int               g;
    exp_t             e;
    logic [N_REQ-1:0] exp_rdy;
    logic             exp_vld;
    @(negedge clk);
    g = -1;
    if (outstanding < FIFO_DEPTH)
      for (int k = 0; k < N_REQ; k++)
        if (g < 0 && req_vld[(rr_m + k) % N_REQ]) g = (rr_m + k) % N_REQ;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    chk("mul_vld", 64'({mul_a_vld, mul_b_vld}), 64'({prev_acc, prev_acc}));
    if (prev_acc) chk("mul_dat", 64'({mul_a_dat, mul_b_dat}), 64'({prev_a, prev_b}));
    exp_vld = (exp_q.size() != 0) && (exp_q[0].ready <= cyc);
    chk("res_vld", 64'(res_vld), 64'(exp_vld));
    last_req_rdy = req_rdy;
    last_res_vld = res_vld;
    last_res_dat = res_dat;
    last_res_id  = res_id;
    if ((req_vld & req_rdy) != '0) dut_acc++;
    if (exp_vld && res_vld) begin
      e = exp_q[0];
      chk("res_dat", 64'(res_dat), 64'(e.dat));
      chk("res_id", 64'(res_id), 64'(e.id));
      if (res_rdy) begin
        void'(exp_q.pop_front());
        outstanding--;
        dut_pop++;
        last_pop_dat = res_dat;
        last_pop_id  = res_id;
        $display("cyc %0d result id=%0d dat=0x%08h", cyc, res_id, res_dat);
      end
    end
    if (g >= 0) begin
      e.id    = ID_W'(g);
      e.dat   = a_val[g] * b_val[g];
      e.ready = cyc + RES_LAT;
      exp_q.push_back(e);
      outstanding++;
      rr_m     = (g + 1) % N_REQ;
      prev_acc = 1'b1;
      prev_a   = a_val[g];
      prev_b   = b_val[g];
    end else begin
      prev_acc = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_vld = '0;
    res_rdy = 1'b1;
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) step();
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int  acc_cyc;
    bit  seen;
    n_cmp = 0; n_err = 0; cyc = 0; dut_acc = 0; dut_pop = 0;
    rst = 1'b1; mul_clr = 1'b1; req_vld = '1; res_rdy = 1'b0;
    rand_ops();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
`ifdef SIF_MULT_ARB_STATS_EN
    chk("reset_stats", {stat_issue, stat_stall}, 64'd0);
`endif
    rst = 1'b0; mul_clr = 1'b0; req_vld = '0;
    @(posedge clk);
    #1;

    // Backpressure: exactly FIFO_DEPTH accepts, then one pop buys exactly one more.
    req_vld = '1; res_rdy = 1'b0; dut_acc = 0;
    repeat (20) begin rand_ops(); step(); end
    chk("bp_accepts", 64'(dut_acc), 64'd8);
`ifdef SIF_MULT_ARB_STATS_EN
    chk("stat_issue", 64'(stat_issue), 64'd8);
    chk("stat_stall", 64'(stat_stall), 64'd12);
`endif
    dut_acc = 0; dut_pop = 0; res_rdy = 1'b1;
    rand_ops(); step();
    res_rdy = 1'b0;
    repeat (5) begin rand_ops(); step(); end
    chk("bp_extra_accept", 64'(dut_acc), 64'd1);
    chk("bp_one_pop", 64'(dut_pop), 64'd1);
    drain();

    // Single request 3*5 from requester 0.
    req_vld = 4'b0001; a_val[0] = 32'd3; b_val[0] = 32'd5; drive_ops(); res_rdy = 1'b1;
    step();
    chk("single_req_rdy", 64'(last_req_rdy), 64'b0001);
    acc_cyc = cyc - 1;
    req_vld = '0;
    chk("single_mul_in", 64'({mul_a_vld, mul_a_dat, mul_b_dat[7:0]}), {1'b1, 32'd3, 8'd5});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (last_res_vld) begin
        seen = 1'b1;
        chk("single_latency", 64'(cyc - 1 - acc_cyc), 64'(RES_LAT));
        chk("single_res", 64'({last_res_id, last_res_dat}), {2'd0, 32'd15});
      end
    end
    if (!seen) chk("single_res_timeout", 64'(seen), 64'd1);
    drain();

    // Round-robin order from pointer 1 (last grant was requester 0).
    tbl[0] = '{4'b0000, 4'b0000}; tbl[1] = '{4'b0010, 4'b0010};
    tbl[2] = '{4'b1001, 4'b1000}; tbl[3] = '{4'b1001, 4'b0001};
    tbl[4] = '{4'b1111, 4'b0010}; tbl[5] = '{4'b0011, 4'b0001};
    tbl[6] = '{4'b0011, 4'b0010}; tbl[7] = '{4'b0100, 4'b0100};
    tbl[8] = '{4'b0111, 4'b0001}; tbl[9] = '{4'b0000, 4'b0000};
    res_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_vld = tbl[i].vld;
      rand_ops();
      step();
      chk($sformatf("tbl%0d_rdy", i), 64'(last_req_rdy), 64'(tbl[i].exp_rdy));
    end
    drain();

    // All requesters valid, consumer always ready: one issue per cycle.
    req_vld = '1; dut_acc = 0;
    repeat (16) begin rand_ops(); step(); end
    chk("rot_accepts", 64'(dut_acc), 64'd16);
    drain();

    // Random traffic with alternating light and heavy backpressure.
    for (int i = 0; i < 400; i++) begin
      req_vld = N_REQ'($urandom_range(0, 15));
      res_rdy = ((i % 64) < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      rand_ops();
      step();
    end
    drain();

    // Reset with three products in flight and results queued.
    res_rdy = 1'b0; req_vld = '1;
    repeat (6) begin rand_ops(); step(); end
    req_vld = '0;
    repeat (2) step();
    chk("pre_rst_res_vld", 64'(res_vld), 64'd1);
    rst = 1'b1; req_vld = '1;
    #1;
    check_reset("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0; req_vld = '0; res_rdy = 1'b1;
    model_reset();
    cyc++;
    repeat (6) step();
    chk("drop_err_flag", 64'(dut.drop_err_reg), 64'd1);
    req_vld = 4'b0100; a_val[2] = 32'd7; b_val[2] = 32'd9; drive_ops();
    step();
    dut_pop = 0;
    drain();
    chk("post_rst_pops", 64'(dut_pop), 64'd1);
    chk("post_rst_res", 64'({last_pop_id, last_pop_dat}), {2'd2, 32'd63});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
